// File: rtl/pipe_pkg.sv
// Shared types and constants for the myCPU five-stage hazard controller.
// Scoreboard slot layout and EX operand forwarding source codes.
package pipe_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } sb_slot_t;

  localparam sb_slot_t SLOT_EMPTY = '{
    valid:   1'b0,
    rd:      5'd0,
    we:      1'b0,
    is_load: 1'b0
  };

endpackage

// File: rtl/fwd_unit.sv
// Per-source match against the EX and MEM scoreboard slots.
// Yields the forwarding select and a load-use hit on the EX slot.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic       used_i,
  input  sb_slot_t   ex_i,
  input  sb_slot_t   mem_i,
  output logic [1:0] sel_o,
  output logic       ld_hit_o
);

  logic ex_hit;
  logic mem_hit;
  logic unused_mem_ld;

  assign ex_hit = used_i & ex_i.valid & ex_i.we
                & (ex_i.rd != 5'd0) & (ex_i.rd == rs_i);

  assign mem_hit = used_i & mem_i.valid & mem_i.we
                 & (mem_i.rd != 5'd0) & (mem_i.rd == rs_i);

  assign ld_hit_o = ex_hit & ex_i.is_load;

  assign unused_mem_ld = mem_i.is_load;

  // Youngest producer wins when both slots match.
  always_comb begin
    sel_o = FWD_RF;
    priority case (1'b1)
      ex_hit:  sel_o = FWD_EXMEM;
      mem_hit: sel_o = FWD_MEMWB;
      default: sel_o = FWD_RF;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the five-stage myCPU pipe:
// scoreboard, stall/flush, registered forwarding, bus watchdog.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic       cpu_clk,
  input  logic       cpu_rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_we,
  input  logic       id_is_load,
  input  logic       ex_br_taken,
  input  logic       mem_req,
  input  logic       bus_ready,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_stall,
  output logic       exmem_stall,
  output logic       memwb_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       bus_err
);

  localparam logic [15:0] TIMEOUT = 16'(BUS_TIMEOUT);

  sb_slot_t ex_q, mem_q, wb_q;
  sb_slot_t ex_d, mem_d, wb_d;
  sb_slot_t id_slot;

  logic [1:0] fa_q, fb_q, fa_d, fb_d;
  logic [1:0] fa_c, fb_c;
  logic       a_ld, b_ld;

  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic bus_wait, branch, load_use;
  logic unused_wb;

  fwd_unit u_fwd_a (
    .rs_i     (id_rs1),
    .used_i   (id_rs1_used),
    .ex_i     (ex_q),
    .mem_i    (mem_q),
    .sel_o    (fa_c),
    .ld_hit_o (a_ld)
  );

  fwd_unit u_fwd_b (
    .rs_i     (id_rs2),
    .used_i   (id_rs2_used),
    .ex_i     (ex_q),
    .mem_i    (mem_q),
    .sel_o    (fb_c),
    .ld_hit_o (b_ld)
  );

  assign bus_wait = mem_req & ~bus_ready;
  assign branch   = ~bus_wait & ex_br_taken;
  assign load_use = ~bus_wait & ~ex_br_taken & (a_ld | b_ld);

  assign id_slot = '{
    valid:   id_valid,
    rd:      id_rd,
    we:      id_we,
    is_load: id_is_load
  };

  // WB is tracked for completeness; write-first RF needs no WB forward.
  assign unused_wb = ^wb_q;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    fa_d  = fa_q;
    fb_d  = fb_q;
    if (!bus_wait) begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (branch | load_use | ~id_valid) begin
        ex_d = SLOT_EMPTY;
        fa_d = FWD_RF;
        fb_d = FWD_RF;
      end else begin
        ex_d = id_slot;
        fa_d = fa_c;
        fb_d = fb_c;
      end
    end
  end

  always_comb begin
    cnt_d = 16'd0;
    if (bus_wait) begin
      cnt_d = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + 16'd1;
    end
    err_d = err_q | (cnt_d == TIMEOUT);
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      ex_q  <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
      wb_q  <= SLOT_EMPTY;
      fa_q  <= FWD_RF;
      fb_q  <= FWD_RF;
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      fa_q  <= fa_d;
      fb_q  <= fb_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign pc_stall    = bus_wait | load_use;
  assign ifid_stall  = bus_wait | load_use;
  assign idex_stall  = bus_wait;
  assign exmem_stall = bus_wait;
  assign memwb_stall = bus_wait;
  assign ifid_flush  = branch;
  assign idex_flush  = branch | load_use;
  assign fwd_a_sel   = fa_q;
  assign fwd_b_sel   = fb_q;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan cases plus
// random traffic against an in-flight-instruction model.
module tb_pipe_hazard_ctrl;

  localparam int T = 4;

  logic       cpu_clk = 1'b0;
  logic       cpu_rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used;
  logic       id_we, id_is_load;
  logic       ex_br_taken, mem_req, bus_ready;
  logic       pc_stall, ifid_stall, idex_stall;
  logic       exmem_stall, memwb_stall;
  logic       ifid_flush, idex_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       bus_err;

  int tests = 0;
  int fails = 0;

  // model: index 0 = instr in EX, 1 = MEM, 2 = WB
  bit         mv[3];
  logic [4:0] mrd[3];
  bit         mwe[3];
  bit         mld[3];
  logic [1:0] mfa, mfb;
  int         waits;
  bit         merr;

  pipe_hazard_ctrl #(.BUS_TIMEOUT(T)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_is_load  (id_is_load),
    .ex_br_taken (ex_br_taken),
    .mem_req     (mem_req),
    .bus_ready   (bus_ready),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .idex_stall  (idex_stall),
    .exmem_stall (exmem_stall),
    .memwb_stall (memwb_stall),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .bus_err     (bus_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0; mrd[k] = '0; mwe[k] = 0; mld[k] = 0;
    end
    mfa = 2'b00; mfb = 2'b00; waits = 0; merr = 0;
  endtask

  function automatic bit hit(int k, logic [4:0] rs, bit used);
    return used && mv[k] && mwe[k] && rs != 5'd0 && mrd[k] == rs;
  endfunction

  function automatic logic [1:0] pick(logic [4:0] rs, bit used);
    if (hit(0, rs, used)) return 2'b01;
    if (hit(1, rs, used)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic drive(bit v, int rs1, int rs2, bit u1, bit u2,
                       int rd, bit we, bit ld, bit br, bit mq, bit rdy);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_rs1_used = u1; id_rs2_used = u2;
    id_rd = 5'(rd); id_we = we; id_is_load = ld;
    ex_br_taken = br; mem_req = mq; bus_ready = rdy;
    #1;
  endtask

  // compare all outputs with the model, then advance one clock
  task automatic step();
    bit bw, br, lu, enter;
    logic [1:0] ea, eb;
    bw = mem_req && !bus_ready;
    br = !bw && ex_br_taken;
    lu = !bw && !ex_br_taken && mv[0] && mld[0] &&
         (hit(0, id_rs1, id_rs1_used) || hit(0, id_rs2, id_rs2_used));
    chk("pc_stall", pc_stall, bw || lu);
    chk("ifid_stall", ifid_stall, bw || lu);
    chk("idex_stall", idex_stall, bw);
    chk("exmem_stall", exmem_stall, bw);
    chk("memwb_stall", memwb_stall, bw);
    chk("ifid_flush", ifid_flush, br);
    chk("idex_flush", idex_flush, br || lu);
    chk("fwd_a", fwd_a_sel, mfa);
    chk("fwd_b", fwd_b_sel, mfb);
    chk("bus_err", bus_err, merr);
    ea = pick(id_rs1, id_rs1_used);
    eb = pick(id_rs2, id_rs2_used);
    enter = !br && !lu && id_valid;
    @(posedge cpu_clk);
    if (cpu_rst) begin
      model_reset();
    end else begin
      if (!bw) begin
        for (int k = 2; k > 0; k--) begin
          mv[k] = mv[k-1]; mrd[k] = mrd[k-1];
          mwe[k] = mwe[k-1]; mld[k] = mld[k-1];
        end
        mv[0] = enter; mrd[0] = id_rd; mwe[0] = id_we; mld[0] = id_is_load;
        mfa = enter ? ea : 2'b00;
        mfb = enter ? eb : 2'b00;
        waits = 0;
      end else begin
        waits++;
        if (waits >= T) merr = 1;
      end
    end
    @(negedge cpu_clk);
  endtask

  initial begin
    cpu_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    model_reset();
    cpu_rst = 1'b0;

    // reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_fwd_a", fwd_a_sel, 2'b00);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_stall", pc_stall, 1'b0);
    step();

    // addi x5 ; add x6,x5,x5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1);
    step();
    drive(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1);
    chk("exfwd_nostall", pc_stall, 1'b0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("exfwd_a", fwd_a_sel, 2'b01);
    chk("exfwd_b", fwd_b_sel, 2'b01);
    step();

    // lw x7 ; add x8,x7,x0
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1);
    step();
    drive(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 1);
    chk("lu_pc_stall", pc_stall, 1'b1);
    chk("lu_ifid_stall", ifid_stall, 1'b1);
    chk("lu_idex_flush", idex_flush, 1'b1);
    step();
    drive(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 1);
    chk("lu_once", pc_stall, 1'b0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lu_fwd_a", fwd_a_sel, 2'b10);
    chk("lu_fwd_b", fwd_b_sel, 2'b00);
    step();

    // addi x0 ; read x0
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    step();
    drive(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 1);
    chk("x0_nostall", pc_stall, 1'b0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("x0_fwd_a", fwd_a_sel, 2'b00);
    step();

    // branch beats load-use
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 1);
    step();
    drive(1, 9, 0, 1, 0, 10, 1, 0, 1, 0, 1);
    chk("br_ifid_flush", ifid_flush, 1'b1);
    chk("br_idex_flush", idex_flush, 1'b1);
    chk("br_pc_stall", pc_stall, 1'b0);
    step();

    // bus wait with a branch in the middle
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, k == 1, 1, 0);
      chk("bw_pc_stall", pc_stall, 1'b1);
      chk("bw_memwb_stall", memwb_stall, 1'b1);
      chk("bw_flush", ifid_flush | idex_flush, 1'b0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    chk("bw_br_flush", ifid_flush & idex_flush, 1'b1);
    chk("bw_br_nostall", pc_stall, 1'b0);
    step();

    // watchdog then reset
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("wd_err", bus_err, 1'(k >= 4));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("wd_sticky", bus_err, 1'b1);
    step();
    cpu_rst = 1'b1;
    drive(1, 3, 3, 1, 1, 3, 1, 1, 0, 1, 0);
    step();
    cpu_rst = 1'b0;
    drive(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 1);
    chk("post_rst_err", bus_err, 1'b0);
    chk("post_rst_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    chk("post_rst_stall", pc_stall, 1'b0);
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cpu_rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 1),
            $urandom_range(0, 3) != 0);
      step();
    end
    cpu_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
